// File: rtl/namuru_accum_fetch_if.sv
// Wishbone initiator bus plus the accumulation output stream of the Namuru accumulator fetcher.
// The master side is the fetch engine and the slave side is the correlator and stream consumer.
interface namuru_accum_fetch_if;
  logic [31:0] wb_adr_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  logic [31:0] m_data;
  logic [3:0]  m_index;
  logic        m_last;
  logic        m_valid;
  logic        m_ready;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i,
    output m_data, m_index, m_last, m_valid,
    input  m_ready
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o,
    output wb_dat_i, wb_ack_i,
    input  m_data, m_index, m_last, m_valid,
    output m_ready
  );
endinterface

// File: rtl/namuru_accum_fetch.sv
// On a correlator accumulation interrupt, reads the status and new_data registers over Wishbone,
// then streams the ten accumulation words out one beat at a time.
module namuru_accum_fetch #(
  parameter logic [31:0] BASE    = 32'h0000_0000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic                         accum_int,
  input  logic                         err_clr,
  output logic [1:0]                   status_o,
  output logic                         busy,
  output logic                         frame_empty,
  output logic                         err_timeout,
  namuru_accum_fetch_if.master         bus
);

  localparam logic [31:0] STAT_ADR   = BASE + 32'h0000_0380;
  localparam logic [31:0] NEW_ADR    = BASE + 32'h0000_0384;
  localparam logic [3:0]  LAST_IDX   = 4'd9;
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_STAT,
    RD_NEW,
    RD_ACC,
    EMIT,
    GAP
  } state_t;

  state_t      state;
  state_t      state_next;
  state_t      gap_dest;
  state_t      gap_dest_next;
  logic [3:0]  index;
  logic [3:0]  index_next;
  logic [15:0] wait_cnt;

  logic        cyc_q;
  logic        cyc_next;
  logic [31:0] adr_q;
  logic [31:0] adr_next;

  logic [31:0] data_q;
  logic [3:0]  m_index_q;
  logic        last_q;
  logic        valid_q;
  logic [1:0]  status_q;
  logic        empty_q;
  logic        err_q;

  logic        ack_hit;
  logic        wait_expired;
  logic        beat_taken;
  logic        stat_hit;
  logic        empty_hit;
  logic        load_word;
  logic        timeout_hit;

  // An ack only counts while our own strobe is out, so stray acks are ignored.
  assign ack_hit      = bus.wb_ack_i & cyc_q;
  assign wait_expired = (wait_cnt == WAIT_LIMIT);
  assign beat_taken   = valid_q & bus.m_ready;

  always_comb begin
    state_next    = state;
    gap_dest_next = gap_dest;
    index_next    = index;
    stat_hit      = 1'b0;
    empty_hit     = 1'b0;
    load_word     = 1'b0;
    timeout_hit   = 1'b0;

    case (state)
      IDLE: begin
        if (enable && accum_int) begin
          state_next = RD_STAT;
          index_next = 4'd0;
        end
      end

      RD_STAT: begin
        if (ack_hit) begin
          stat_hit      = 1'b1;
          state_next    = GAP;
          gap_dest_next = RD_NEW;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end

      RD_NEW: begin
        if (ack_hit) begin
          if (!bus.wb_dat_i[0]) begin
            empty_hit  = 1'b1;
            state_next = IDLE;
          end else begin
            state_next    = GAP;
            gap_dest_next = RD_ACC;
            index_next    = 4'd0;
          end
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end

      RD_ACC: begin
        if (ack_hit) begin
          load_word  = 1'b1;
          state_next = EMIT;
        end else if (wait_expired) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end

      EMIT: begin
        if (beat_taken) begin
          if (index == LAST_IDX) begin
            state_next = IDLE;
          end else begin
            index_next    = index + 4'd1;
            state_next    = GAP;
            gap_dest_next = RD_ACC;
          end
        end
      end

      GAP: begin
        state_next = gap_dest;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus controls are registered from the upcoming state so cyc/stb/adr change only on clock edges.
  always_comb begin
    cyc_next = 1'b0;
    adr_next = '0;
    case (state_next)
      RD_STAT: begin
        cyc_next = 1'b1;
        adr_next = STAT_ADR;
      end
      RD_NEW: begin
        cyc_next = 1'b1;
        adr_next = NEW_ADR;
      end
      RD_ACC: begin
        cyc_next = 1'b1;
        adr_next = BASE + {26'd0, index_next + 4'd4, 2'b00};
      end
      default: begin
        cyc_next = 1'b0;
        adr_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      gap_dest <= IDLE;
      index    <= '0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
    end else begin
      state    <= state_next;
      gap_dest <= gap_dest_next;
      index    <= index_next;
      cyc_q    <= cyc_next;
      adr_q    <= adr_next;
    end
  end

  // Wait counter restarts on every state change and counts cycles spent waiting for an ack.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state_next != state) begin
      wait_cnt <= '0;
    end else if (cyc_q) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q    <= '0;
      m_index_q <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (load_word) begin
      data_q    <= bus.wb_dat_i;
      m_index_q <= index;
      last_q    <= (index == LAST_IDX);
      valid_q   <= 1'b1;
    end else if (beat_taken) begin
      valid_q   <= 1'b0;
    end
  end

  // A timeout wins over a simultaneous clear so that no error is ever lost.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      status_q <= '0;
      empty_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (stat_hit) begin
        status_q <= bus.wb_dat_i[1:0];
      end
      empty_q <= empty_hit;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.wb_adr_o = adr_q;
  assign bus.wb_cyc_o = cyc_q;
  assign bus.wb_stb_o = cyc_q;
  assign bus.wb_we_o  = 1'b0;
  assign bus.wb_sel_o = 4'hF;
  assign bus.m_data   = data_q;
  assign bus.m_index  = m_index_q;
  assign bus.m_last   = last_q;
  assign bus.m_valid  = valid_q;

  assign status_o    = status_q;
  assign busy        = (state != IDLE);
  assign frame_empty = empty_q;
  assign err_timeout = err_q;

  beat_hold: assert property (@(posedge clk) disable iff (!rstn)
    valid_q && !bus.m_ready |=> valid_q && $stable(data_q) && $stable(m_index_q) && $stable(last_q));

  quiet_while_emit: assert property (@(posedge clk) disable iff (!rstn)
    valid_q |-> !cyc_q);

endmodule

// File: tb/tb_namuru_accum_fetch.sv
// Self-checking bench for namuru_accum_fetch: a Wishbone slave model with programmable latency,
// a stream consumer with programmable back-pressure and a transaction-level reference model.
module tb_namuru_accum_fetch;

  localparam int          TMO     = 8;
  localparam logic [31:0] TB_BASE = 32'h0000_0000;

  typedef struct {
    logic [31:0] stat_word;
    logic [31:0] new_word;
    int          ack_lat;
    int          ready_mode;
    int          stall_beat;
    int          exp_beats;
    int          exp_reads;
    int          exp_empty;
    logic [1:0]  exp_status;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic       accum_int;
  logic       err_clr;
  logic [1:0] status_o;
  logic       busy;
  logic       frame_empty;
  logic       err_timeout;

  namuru_accum_fetch_if bus ();

  namuru_accum_fetch #(.BASE(TB_BASE), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .accum_int   (accum_int),
    .err_clr     (err_clr),
    .status_o    (status_o),
    .busy        (busy),
    .frame_empty (frame_empty),
    .err_timeout (err_timeout),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [0:255];
  int ack_lat    = 4;
  bit ack_never  = 1'b0;
  bit inject_ack = 1'b0;
  int ready_mode = 0;
  int stall_beat = 0;
  int stall_arm  = 0;
  int slv_cnt;

  // Correlator register file: acks after ack_lat strobe cycles, plus an optional stray ack.
  always @(posedge clk) begin
    if (bus.wb_cyc_o && bus.wb_stb_o && !bus.wb_ack_i && !ack_never && slv_cnt >= ack_lat - 1) begin
      bus.wb_ack_i <= 1'b1;
      bus.wb_dat_i <= mem[bus.wb_adr_o[9:2]];
      slv_cnt      <= 0;
    end else begin
      bus.wb_ack_i <= inject_ack;
      slv_cnt      <= (bus.wb_cyc_o && !bus.wb_ack_i) ? slv_cnt + 1 : 0;
    end
  end

  // Stream consumer: always ready, one 20-cycle stall on a chosen beat, or random.
  initial begin
    int left;
    int armed;
    left  = 0;
    armed = 0;
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (armed != stall_arm) begin
        armed = stall_arm;
        left  = 20;
      end
      case (ready_mode)
        1: begin
          if (bus.m_valid && bus.m_index == 4'(stall_beat) && left > 0) begin
            bus.m_ready = 1'b0;
            left--;
          end else begin
            bus.m_ready = 1'b1;
          end
        end
        2: bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b1;
      endcase
    end
  end

  logic [31:0] rd_adr_q [$];
  logic [31:0] beat_dat_q [$];
  int          beat_idx_q [$];
  bit          beat_last_q [$];
  int cyc_cycles   = 0;
  int empty_pulses = 0;
  int stall_cycles = 0;
  int v_static = 0;
  int v_emit   = 0;
  int v_gap    = 0;
  int v_adr    = 0;
  int v_stab   = 0;
  int v_empty  = 0;
  logic        p_cyc   = 1'b0;
  logic        p_ack   = 1'b0;
  logic        p_valid = 1'b0;
  logic        p_ready = 1'b0;
  logic        p_empty = 1'b0;
  logic [31:0] p_adr   = '0;
  logic [36:0] p_beat  = '0;

  // Passive monitor: logs completed reads and beats, and counts bus/stream rule breaks.
  always @(negedge clk) begin
    if (bus.wb_cyc_o) cyc_cycles <= cyc_cycles + 1;
    if (bus.wb_cyc_o && bus.wb_ack_i) rd_adr_q.push_back(bus.wb_adr_o);
    if (bus.m_valid && bus.m_ready) begin
      beat_dat_q.push_back(bus.m_data);
      beat_idx_q.push_back(int'(bus.m_index));
      beat_last_q.push_back(bus.m_last);
    end
    if (bus.m_valid && !bus.m_ready) stall_cycles <= stall_cycles + 1;
    if (frame_empty) empty_pulses <= empty_pulses + 1;
    if (bus.wb_cyc_o != bus.wb_stb_o || bus.wb_we_o || bus.wb_sel_o != 4'hF) v_static <= v_static + 1;
    if (bus.wb_cyc_o && bus.m_valid) v_emit <= v_emit + 1;
    if (p_cyc && p_ack && bus.wb_cyc_o) v_gap <= v_gap + 1;
    if (p_cyc && !p_ack && bus.wb_cyc_o && bus.wb_adr_o != p_adr) v_adr <= v_adr + 1;
    if (p_valid && !p_ready && bus.m_valid && {bus.m_data, bus.m_index, bus.m_last} != p_beat)
      v_stab <= v_stab + 1;
    if (p_empty && frame_empty) v_empty <= v_empty + 1;
    p_cyc   <= bus.wb_cyc_o;
    p_ack   <= bus.wb_ack_i;
    p_adr   <= bus.wb_adr_o;
    p_valid <= bus.m_valid;
    p_ready <= bus.m_ready;
    p_empty <= frame_empty;
    p_beat  <= {bus.m_data, bus.m_index, bus.m_last};
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitBusy(input logic level, input int limit, input string name);
    int n;
    n = 0;
    while (busy !== level && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, busy, level);
  endtask

  task automatic applyStimulus(input string name);
    enable    = 1'b1;
    accum_int = 1'b1;
    waitBusy(1'b1, 50, {name, ".start"});
    repeat (2) @(negedge clk);
    accum_int = 1'b0;
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".cyc"}, bus.wb_cyc_o, 0);
    checkOutput({name, ".stb"}, bus.wb_stb_o, 0);
    checkOutput({name, ".adr"}, bus.wb_adr_o, 0);
    checkOutput({name, ".m_valid"}, bus.m_valid, 0);
    checkOutput({name, ".m_data"}, bus.m_data, 0);
    checkOutput({name, ".m_index"}, bus.m_index, 0);
    checkOutput({name, ".m_last"}, bus.m_last, 0);
    checkOutput({name, ".status"}, status_o, 0);
    checkOutput({name, ".busy"}, busy, 0);
    checkOutput({name, ".frame_empty"}, frame_empty, 0);
    checkOutput({name, ".err_timeout"}, err_timeout, 0);
  endtask

  // Runs one complete fetch and compares it with the transaction-level expectation.
  task automatic runVector(input vec_t v, input string name);
    int rd0;
    int bt0;
    int em0;
    int st0;
    logic [31:0] exp_adr [$];
    logic [31:0] exp_dat [$];
    mem[8'hE0] = v.stat_word;
    mem[8'hE1] = v.new_word;
    ack_lat    = v.ack_lat;
    ready_mode = v.ready_mode;
    stall_beat = v.stall_beat;
    stall_arm++;
    @(negedge clk);
    rd0 = rd_adr_q.size();
    bt0 = beat_dat_q.size();
    em0 = empty_pulses;
    st0 = stall_cycles;
    applyStimulus(name);
    waitBusy(1'b0, 4000, {name, ".done"});
    repeat (3) @(negedge clk);

    exp_adr.push_back(TB_BASE + 32'h380);
    exp_adr.push_back(TB_BASE + 32'h384);
    if (v.new_word[0]) begin
      for (int i = 0; i < 10; i++) begin
        exp_adr.push_back(TB_BASE + 32'(4 * (4 + i)));
        exp_dat.push_back(mem[4 + i]);
      end
    end

    checkOutput({name, ".reads"}, rd_adr_q.size() - rd0, v.exp_reads);
    for (int i = 0; i < exp_adr.size(); i++)
      if (rd0 + i < rd_adr_q.size())
        checkOutput($sformatf("%s.adr%0d", name, i), rd_adr_q[rd0 + i], exp_adr[i]);
    checkOutput({name, ".beats"}, beat_dat_q.size() - bt0, v.exp_beats);
    for (int i = 0; i < exp_dat.size(); i++) begin
      if (bt0 + i < beat_dat_q.size()) begin
        checkOutput($sformatf("%s.data%0d", name, i), beat_dat_q[bt0 + i], exp_dat[i]);
        checkOutput($sformatf("%s.idx%0d", name, i), beat_idx_q[bt0 + i], i);
        checkOutput($sformatf("%s.last%0d", name, i), beat_last_q[bt0 + i], (i == 9) ? 1 : 0);
      end
    end
    checkOutput({name, ".empty"}, empty_pulses - em0, v.exp_empty);
    checkOutput({name, ".status"}, status_o, v.exp_status);
    if (v.ready_mode == 1)
      checkOutput({name, ".stall"}, stall_cycles - st0, 20);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vt [5];
    int   c0;
    int   bt0;
    int   n;

    vt[0] = '{32'h0000_0002, 32'h0000_0001, 4, 0, 0, 10, 12, 0, 2'b10};
    vt[1] = '{32'h0000_0001, 32'h0000_0000, 4, 0, 0, 0, 2, 1, 2'b01};
    vt[2] = '{32'h0000_0003, 32'h0000_0001, 1, 1, 3, 10, 12, 0, 2'b11};
    vt[3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 2, 0, 0, 0, 2, 1, 2'b10};
    vt[4] = '{32'h0000_0000, 32'h0000_0003, 6, 2, 0, 10, 12, 0, 2'b00};

    for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    for (int i = 0; i < 10; i++) mem[4 + i] = 32'h11 + 32'(i);

    rstn      = 1'b0;
    enable    = 1'b0;
    accum_int = 1'b0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    checkOutput("reset.we", bus.wb_we_o, 0);
    checkOutput("reset.sel", bus.wb_sel_o, 4'hF);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) runVector(vt[i], $sformatf("vec%0d", i));

    // Slave never answers the status read.
    ack_never = 1'b1;
    c0 = cyc_cycles;
    applyStimulus("tmo");
    waitBusy(1'b0, 100, "tmo.end");
    checkOutput("tmo.cyc_cycles", cyc_cycles - c0, TMO);
    checkOutput("tmo.err", err_timeout, 1);
    checkOutput("tmo.valid", bus.m_valid, 0);
    checkOutput("tmo.cyc_now", bus.wb_cyc_o, 0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("tmo.cleared", err_timeout, 0);
    err_clr = 1'b1;
    applyStimulus("tmo2");
    waitBusy(1'b0, 100, "tmo2.end");
    checkOutput("tmo2.collide", err_timeout, 1);
    err_clr = 1'b0;
    @(negedge clk);
    checkOutput("tmo2.held", err_timeout, 1);
    ack_never = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during the read of accumulation word 5.
    mem[8'hE0] = 32'h2;
    mem[8'hE1] = 32'h1;
    ack_lat    = 6;
    ready_mode = 0;
    applyStimulus("rst");
    n = 0;
    while (!(bus.wb_cyc_o && bus.wb_adr_o == 32'h24) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst.reach_idx5", bus.wb_adr_o, 32'h24);
    rstn = 1'b0;
    @(negedge clk);
    checkResetValues("rst");
    inject_ack = 1'b1;
    rstn       = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.late_ack_busy", busy, 0);
    checkOutput("rst.late_ack_status", status_o, 0);
    checkOutput("rst.late_ack_valid", bus.m_valid, 0);
    runVector(vt[0], "rst.restart");

    // Enable gating, and dropping enable mid-sequence.
    enable    = 1'b0;
    accum_int = 1'b1;
    c0 = cyc_cycles;
    repeat (20) @(negedge clk);
    checkOutput("en.no_bus", cyc_cycles - c0, 0);
    checkOutput("en.idle", busy, 0);
    bt0 = beat_dat_q.size();
    enable = 1'b1;
    waitBusy(1'b1, 10, "en.start");
    enable = 1'b0;
    repeat (2) @(negedge clk);
    accum_int = 1'b0;
    waitBusy(1'b0, 4000, "en.done");
    checkOutput("en.beats", beat_dat_q.size() - bt0, 10);

    for (int r = 0; r < 6; r++) begin
      vec_t v;
      logic [31:0] w;
      for (int i = 0; i < 10; i++) mem[4 + i] = $urandom;
      w    = $urandom;
      w[0] = ($urandom_range(0, 3) != 0);
      v.stat_word  = $urandom;
      v.new_word   = w;
      v.ack_lat    = $urandom_range(1, 6);
      v.ready_mode = 2;
      v.stall_beat = 0;
      v.exp_beats  = w[0] ? 10 : 0;
      v.exp_reads  = w[0] ? 12 : 2;
      v.exp_empty  = w[0] ? 0 : 1;
      v.exp_status = v.stat_word[1:0];
      runVector(v, $sformatf("rand%0d", r));
    end

    checkOutput("proto.static", v_static, 0);
    checkOutput("proto.bus_in_emit", v_emit, 0);
    checkOutput("proto.gap", v_gap, 0);
    checkOutput("proto.adr_stable", v_adr, 0);
    checkOutput("proto.beat_stable", v_stab, 0);
    checkOutput("proto.empty_width", v_empty, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/namuru_accum_fetch.md
NAMURU_ACCUM_FETCH -- requirements
Module: namuru_accum_fetch

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_0000; word-aligned Wishbone base address of the correlator register file.
REQ-002 SHALL have parameter TIMEOUT, default 255; maximum cycles to wait for wb_ack_i per transfer (1..65535).
REQ-003 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port enable  in  1  fetch sequences may start only while high.
REQ-006 SHALL have port accum_int  in  1  correlator accumulation interrupt (level; cleared by the correlator when its status register is read).
REQ-007 SHALL have port wb_adr_o  out  32  Wishbone initiator address.
REQ-008 SHALL have ports wb_cyc_o, wb_stb_o  out  1 each  cycle/strobe, always asserted together.
REQ-009 SHALL have ports wb_we_o  out  1  (constant 0) and wb_sel_o  out  4  (constant 4'hF).
REQ-010 SHALL have ports wb_dat_i  in  32  read data, and wb_ack_i  in  1  acknowledge.
REQ-011 SHALL have ports m_data  out  32, m_index  out  4 (0..9), m_last  out  1, m_valid  out  1, m_ready  in  1  accumulation output stream.
REQ-012 SHALL have ports status_o  out  2  last status word bits [1:0]; busy  out  1; frame_empty  out  1 (one-cycle pulse); err_timeout  out  1 (sticky); err_clr  in  1.

Function
REQ-013 States SHALL be IDLE, RD_STAT, RD_NEW, RD_ACC, EMIT, GAP.
REQ-014 IDLE -> RD_STAT when enable & accum_int; busy SHALL be high in every state except IDLE.
REQ-015 Each read state SHALL drive wb_cyc_o/wb_stb_o high with a stable wb_adr_o until the first cycle wb_ack_i is high, and SHALL sample wb_dat_i on that edge.
REQ-016 cyc/stb SHALL deassert the cycle after ack; GAP SHALL hold them low for exactly one cycle before any further transfer.
REQ-017 RD_STAT address SHALL be BASE+0x380 (word 0xE0); status_o <= wb_dat_i[1:0]; then GAP -> RD_NEW.
REQ-018 RD_NEW address SHALL be BASE+0x384 (word 0xE1); if wb_dat_i[0]==0, frame_empty SHALL pulse and the FSM SHALL return to IDLE; else GAP -> RD_ACC with index 0.
REQ-019 RD_ACC address SHALL be BASE+4*(4+index), index 0..9 (words 0x04..0x0D); on ack, m_data <= wb_dat_i, m_index <= index, m_last <= (index==9), then EMIT.
REQ-020 EMIT SHALL hold m_valid high with m_data/m_index/m_last stable until m_valid & m_ready; on that edge m_valid SHALL clear, and the FSM SHALL go IDLE if index==9, else index+1 and GAP -> RD_ACC.
REQ-021 A 16-bit wait counter SHALL clear on entry to each read state and increment per unacked cycle; reaching TIMEOUT SHALL drop cyc/stb, set err_timeout, discard the word, and return to IDLE with m_valid low.
REQ-022 err_timeout SHALL clear only on err_clr; if err_clr and a new timeout coincide, it SHALL remain set.
REQ-023 accum_int changes during a sequence SHALL be ignored; a new sequence SHALL start only from IDLE.
REQ-024 enable low SHALL not abort an in-progress sequence.
REQ-025 An ack arriving while cyc/stb are low SHALL be ignored.

Reset
REQ-026 While rstn is low at a clock edge: state IDLE, wb_cyc_o=wb_stb_o=0, wb_adr_o=0, m_valid=0, m_data=0, m_index=0, m_last=0, status_o=0, busy=0, frame_empty=0, err_timeout=0, wait counter and index 0.
REQ-027 Reset asserted mid-transfer SHALL abort immediately; any in-flight ack after reset SHALL be ignored.

Verification
REQ-028 Slave model acking reads after 4 cycles, status 2'b10, new_data 1, regs 0x04..0x0D = 0x11..0x1A, m_ready=1 -> 10 beats, indices 0..9, data 0x11..0x1A, m_last only on beat 9, busy low afterwards.
REQ-029 new_data = 0 -> exactly two Wishbone reads (0x380, 0x384), one frame_empty pulse, no m_valid.
REQ-030 m_ready low for 20 cycles on beat 3 -> m_valid/m_data held stable, no Wishbone activity until handshake, all 10 beats delivered in order.
REQ-031 TIMEOUT=8, slave never acks RD_STAT -> cyc/stb drop after 8 wait cycles, err_timeout=1, IDLE; err_clr pulse -> err_timeout=0.
REQ-032 rstn low during RD_ACC index 5 -> all REQ-026 values next cycle; late ack ignored; next accum_int restarts at 0x380.
REQ-033 accum_int high with enable=0 -> no bus activity; enable raised -> sequence starts.
